// File: rtl/tx_phy_pkg.sv
// Shared definitions for the PHY TX path.
// Holds the link FSM state encoding, the ordered-set words (COM/IDL/SKP),
// and a small helper that sizes counters with a floor on their width.
package tx_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_ACTIVE = 2'd2
    } tx_state_t;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] COM_WORD  = 32'hBCBC_BCBC;
    localparam logic [31:0] IDL_WORD  = 32'h7C7C_7C7C;
    localparam logic [31:0] SKP_WORD  = 32'h1C1C_1C1C;

    // Bits needed to hold values 0..n, but never fewer than min_w.
    function automatic int cnt_w(input int n, input int min_w);
        int w;
        w = $clog2(n + 1);
        return (w > min_w) ? w : min_w;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a burst limit.
// The current owner keeps winning contention until it has taken MAX_BURST
// consecutive grants; then the other requester takes over. A lone requester
// is always granted. Nothing changes while en_i is low.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : arbitration allowed this cycle
//   req_i[1:0]   : requests from source 1 / source 0
//   gnt_o[1:0]   : one-hot (or zero) combinational grant
module rr_arbiter_2 #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    localparam int            BW   = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    logic          owner_q, owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          pick;

    always_comb begin
        gnt_o   = 2'b00;
        owner_d = owner_q;
        burst_d = burst_q;
        pick    = owner_q;
        if (en_i) begin
            if (&req_i) pick = (burst_q >= BMAX) ? ~owner_q : owner_q;
            else        pick = req_i[1];
            if (|req_i) begin
                gnt_o = pick ? 2'b10 : 2'b01;
                if (pick != owner_q) begin
                    owner_d = pick;
                    burst_d = BW'(1);
                end else if (burst_q < BMAX) begin
                    burst_d = burst_q + BW'(1);
                end
            end else begin
                // Owner let go with nobody waiting: its next grant starts a fresh run.
                burst_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= 1'b0;
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Link-level TX arbiter: IDLE -> TRAIN (TRAIN_LEN COM words) -> ACTIVE.
// In ACTIVE it muxes two sources onto the PHY word stream with one cycle of
// latency, fills empty cycles with IDL and periodically inserts a SKP word.
// Ports:
//   clk_f, reset         : clock, asynchronous active-high reset
//   enable               : link enable
//   req_0/1, data_0/1    : source requests and words
//   gnt_0/1              : combinational grants (word captured at next edge)
//   data_input/valid/active : registered PHY TX outputs
module tx_arbiter
    import tx_phy_pkg::*;
#(
    parameter int TRAIN_LEN     = 4,
    parameter int MAX_BURST     = 4,
    parameter int SKIP_INTERVAL = 16
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic        enable,
    input  logic        req_0,
    input  logic        req_1,
    input  logic [31:0] data_0,
    input  logic [31:0] data_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic [31:0] data_input,
    output logic        valid,
    output logic        active
);

    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam int SW = cnt_w(SKIP_INTERVAL, 5);

    tx_state_t     state_q, state_d;
    logic [TW-1:0] train_q, train_d;
    logic [SW-1:0] skp_q, skp_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          active_q, active_d;
    logic [1:0]    gnt;
    logic          skp_now, arb_en;

    // SKP slot pre-empts arbitration; a request seen here simply waits.
    assign skp_now = (state_q == ST_ACTIVE) && (skp_q == SW'(SKIP_INTERVAL));
    assign arb_en  = (state_q == ST_ACTIVE) && enable && !skp_now;

    rr_arbiter_2 #(.MAX_BURST(MAX_BURST)) u_rr (
        .clk_i (clk_f),
        .rst_i (reset),
        .en_i  (arb_en),
        .req_i ({req_1, req_0}),
        .gnt_o (gnt)
    );

    assign gnt_0 = gnt[0];
    assign gnt_1 = gnt[1];

    // State register
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            train_q <= '0;
            skp_q   <= '0;
        end else begin
            state_q <= state_d;
            train_q <= train_d;
            skp_q   <= skp_d;
        end
    end

    // Next state; the SKP counter only runs in ACTIVE and restarts on entry.
    always_comb begin
        state_d = state_q;
        train_d = train_q;
        skp_d   = '0;
        if (!enable) begin
            state_d = ST_IDLE;
            train_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRAIN;
                    train_d = '0;
                end
                ST_TRAIN: begin
                    if (train_q == TW'(TRAIN_LEN - 1)) begin
                        state_d = ST_ACTIVE;
                        train_d = '0;
                    end else begin
                        train_d = train_q + TW'(1);
                    end
                end
                ST_ACTIVE: skp_d = skp_now ? '0 : skp_q + SW'(1);
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output values to register at the coming edge.
    always_comb begin
        data_d   = ZERO_WORD;
        valid_d  = 1'b0;
        active_d = 1'b0;
        if (enable) begin
            case (state_q)
                ST_TRAIN: begin
                    data_d   = COM_WORD;
                    valid_d  = 1'b1;
                    active_d = 1'b1;
                end
                ST_ACTIVE: begin
                    active_d = 1'b1;
                    if (skp_now) begin
                        data_d  = SKP_WORD;
                        valid_d = 1'b1;
                    end else if (gnt[0]) begin
                        data_d  = data_0;
                        valid_d = 1'b1;
                    end else if (gnt[1]) begin
                        data_d  = data_1;
                        valid_d = 1'b1;
                    end else begin
                        data_d  = IDL_WORD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            data_q   <= ZERO_WORD;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            active_q <= active_d;
        end
    end

    assign data_input = data_q;
    assign valid      = valid_q;
    assign active     = active_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios plus a random phase, all checked
// against a cycle-level reference model through an expected-output queue.
module tb_tx_arbiter;

    localparam int TRAIN_LEN     = 4;
    localparam int MAX_BURST     = 4;
    localparam int SKIP_INTERVAL = 16;
    localparam logic [31:0] COM = 32'hBCBCBCBC;
    localparam logic [31:0] IDL = 32'h7C7C7C7C;
    localparam logic [31:0] SKP = 32'h1C1C1C1C;

    logic        clk_f = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        req_0 = 1'b0, req_1 = 1'b0;
    logic [31:0] data_0 = '0, data_1 = '0;
    logic        gnt_0, gnt_1, valid, active;
    logic [31:0] data_input;

    tx_arbiter #(.TRAIN_LEN(TRAIN_LEN), .MAX_BURST(MAX_BURST), .SKIP_INTERVAL(SKIP_INTERVAL)) dut (
        .clk_f(clk_f), .reset(reset), .enable(enable),
        .req_0(req_0), .req_1(req_1), .data_0(data_0), .data_1(data_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .data_input(data_input), .valid(valid), .active(active)
    );

    always #5 clk_f = ~clk_f;

    typedef struct packed {
        logic [31:0] d;
        logic        v;
        logic        a;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state: link mode (0 idle, 1 training, 2 active),
    // words of training sent, active cycles since the last SKP,
    // current burst owner and length of its current run.
    int   m_mode, m_train, m_skp, m_owner, m_run;
    logic last_g0, last_g1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_train = 0; m_skp = 0; m_owner = 0; m_run = 0;
        last_g0 = 1'b0; last_g1 = 1'b0;
    endtask

    // One clock of the link as described by its rules, given current inputs.
    task automatic model(output logic g0, output logic g1, output exp_t e);
        int w;
        g0 = 1'b0; g1 = 1'b0;
        e.d = 32'h0; e.v = 1'b0; e.a = 1'b0;
        if (!enable) begin
            m_mode = 0; m_train = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_train = 0;
        end else if (m_mode == 1) begin
            e.d = COM; e.v = 1'b1; e.a = 1'b1;
            m_train++;
            if (m_train == TRAIN_LEN) begin
                m_mode = 2; m_skp = 0;
            end
        end else begin
            e.a = 1'b1; e.d = IDL;
            if (m_skp == SKIP_INTERVAL) begin
                e.d = SKP; e.v = 1'b1; m_skp = 0;
            end else begin
                m_skp++;
                if (req_0 || req_1) begin
                    if (req_0 && req_1) w = (m_run >= MAX_BURST) ? 1 - m_owner : m_owner;
                    else                w = req_1 ? 1 : 0;
                    if (w == m_owner) begin
                        if (m_run < MAX_BURST) m_run++;
                    end else begin
                        m_owner = w; m_run = 1;
                    end
                    if (w == 0) begin g0 = 1'b1; e.d = data_0; end
                    else        begin g1 = 1'b1; e.d = data_1; end
                    e.v = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end
    endtask

    // Called just after a negedge with inputs settled; ends at the next negedge.
    task automatic step();
        logic eg0, eg1;
        exp_t e;
        #1;
        model(eg0, eg1, e);
        chk("gnt", {62'd0, gnt_1, gnt_0}, {62'd0, eg1, eg0});
        sb_q.push_back(e);
        last_g0 = eg0; last_g1 = eg1;
        @(posedge clk_f);
        @(negedge clk_f);
    endtask

    // Reset between edges: outputs must clear before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_data", {32'd0, data_input}, 64'd0);
        chk("rst_valid_active_gnt", {60'd0, valid, active, gnt_1, gnt_0}, 64'd0);
        sb_q.delete();
        @(posedge clk_f);
        @(negedge clk_f);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic upd_reqs(input int p);
        if (last_g0) req_0 = 1'b0;
        if (last_g1) req_1 = 1'b0;
        if (!req_0 && $urandom_range(99) < p) begin req_0 = 1'b1; data_0 = $urandom; end
        if (!req_1 && $urandom_range(99) < p) begin req_1 = 1'b1; data_1 = $urandom; end
    endtask

    // Monitor: compares each registered output word against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_f);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("data_input", {32'd0, data_input}, {32'd0, e.d});
                chk("valid", {63'd0, valid}, {63'd0, e.v});
                chk("active", {63'd0, active}, {63'd0, e.a});
            end
        end
    end

    initial begin
        int n;
        model_reset();
        repeat (2) @(negedge clk_f);
        chk("reset_outputs", {29'd0, data_input, valid, active, gnt_1, gnt_0}, 64'd0);
        reset = 1'b0;

        // Training then IDL fill.
        enable = 1'b1;
        repeat (TRAIN_LEN + 2) step();

        // Single source, three words.
        repeat (3) begin
            req_0 = 1'b1; data_0 = 32'hFFFFEEEE; step();
        end
        req_0 = 1'b0;
        step();

        // Both sources held: bursts of MAX_BURST alternate.
        req_0 = 1'b1; data_0 = 32'h3FE115E6;
        req_1 = 1'b1; data_1 = 32'hCCEEEEEE;
        repeat (12) step();
        req_0 = 1'b0; req_1 = 1'b0;
        step();

        // Long single-source stream crosses SKP insertions.
        req_0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (last_g0) data_0 = 32'h5000_0000 + i;
            step();
        end
        req_0 = 1'b0;

        // Enable dropped right after source 1 is granted.
        req_1 = 1'b1; data_1 = 32'hAAAA1234;
        n = 0;
        step();
        while (!last_g1 && n < 4) begin step(); n++; end
        chk("en_drop_granted", {63'd0, last_g1}, 64'd1);
        enable = 1'b0; req_1 = 1'b0;
        repeat (3) step();

        // Reset in the middle of a burst, then full retrain.
        enable = 1'b1;
        repeat (TRAIN_LEN + 2) step();
        req_0 = 1'b1; data_0 = 32'h1234_5678;
        req_1 = 1'b1; data_1 = 32'h8765_4321;
        repeat (3) step();
        do_reset();
        req_0 = 1'b0; req_1 = 1'b0;
        repeat (TRAIN_LEN + 3) step();

        // Random traffic with enable toggles and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (enable ? ($urandom_range(99) < 2) : ($urandom_range(99) < 20)) enable = ~enable;
            upd_reqs(60);
            if ($urandom_range(299) == 0) do_reset();
            else                           step();
        end

        @(posedge clk_f);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter TRAIN_LEN, 4, number of COM training words sent before ACTIVE.
REQ-002 SHALL have parameter MAX_BURST, 4, maximum consecutive grants to one source while the other requests.
REQ-003 SHALL have parameter SKIP_INTERVAL, 16, number of ACTIVE cycles between SKP insertions.
REQ-004 SHALL have port clk_f  input  1  single clock; all state updates on posedge clk_f.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  link enable; high requests training then ACTIVE.
REQ-007 SHALL have ports req_0 / req_1  input  1  source request, held until granted.
REQ-008 SHALL have ports data_0 / data_1  input  32  source word, stable while req high.
REQ-009 SHALL have ports gnt_0 / gnt_1  output  1  combinational grant; word captured at this edge.
REQ-010 SHALL have port data_input  output  32  registered word to PHY TX.
REQ-011 SHALL have port valid  output  1  registered; data_input carries a word.
REQ-012 SHALL have port active  output  1  registered; link is in TRAIN or ACTIVE.

Function
REQ-013 SHALL implement states IDLE, TRAIN, ACTIVE.
REQ-014 IDLE: active=0, valid=0, data_input=32'h00000000, gnts 0; enable=1 -> TRAIN.
REQ-015 TRAIN: each cycle drives data_input=32'hBCBCBCBC (COM), valid=1, active=1; after exactly TRAIN_LEN words -> ACTIVE.
REQ-016 ACTIVE: grants one requester per cycle; granted word appears on data_input with valid=1 on the next posedge (latency 1).
REQ-017 ACTIVE with no request: data_input=32'h7C7C7C7C (IDL), valid=0, active=1.
REQ-018 Arbitration: round-robin; on first contention source 0 wins; the winner keeps the grant while its req holds and burst count < MAX_BURST; at MAX_BURST with the other source requesting, grant passes to the other source.
REQ-019 Burst counter SHALL reset to 1 on every switch of winner and whenever the winner drops req.
REQ-020 Never assert gnt_0 and gnt_1 in the same cycle; never assert any grant outside ACTIVE.
REQ-021 SKP: a 5-bit-minimum counter counts ACTIVE cycles; when it reaches SKIP_INTERVAL, that cycle drives 32'h1C1C1C1C with valid=1, no grant, counter wraps to 0; burst count and RR pointer unchanged.
REQ-022 enable=0 in TRAIN or ACTIVE: grants forced 0 that cycle, next state IDLE; a word granted in the prior cycle still appears on data_input.
REQ-023 enable=0 in IDLE: remains IDLE.
REQ-024 Request arriving in the SKP cycle SHALL wait; no word is dropped or duplicated.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, data_input=0, valid=0, active=0, gnts 0, burst count 0, SKP counter 0, RR pointer to source 0, regardless of clock.
REQ-026 Reset asserted mid-burst SHALL discard the in-flight word; after release, operation restarts from IDLE with full TRAIN.

Structure
REQ-027 COM/IDL/SKP word constants and state encodings SHALL live in shared package tx_phy_pkg.
REQ-028 The two-way round-robin with burst limit SHALL be sub-module rr_arbiter_2; tx_arbiter holds FSM, SKP counter, output registers.

Verification
REQ-029 reset, enable=1 -> 4 cycles of data_input=BCBCBCBC valid=1 active=1, then IDL with valid=0.
REQ-030 ACTIVE, req_0 only, data_0=FFFFEEEE for 3 cycles -> gnt_0 3 cycles, data_input=FFFFEEEE valid=1 one cycle later each.
REQ-031 req_0 and req_1 held (data_0=3FE115E6, data_1=CCEEEEEE) -> grants 0,0,0,0,1,1,1,1,0..., never both.
REQ-032 16 ACTIVE cycles with req_0 held -> 17th cycle data_input=1C1C1C1C valid=1, gnt_0=0, then stream resumes without loss.
REQ-033 reset asserted between clock edges mid-burst -> outputs 0 immediately; enable held -> TRAIN re-runs 4 words.
REQ-034 enable dropped during burst with data_1=AAAA1234 granted -> AAAA1234 output once, then IDLE active=0.
